// File: rtl/float_pkg.sv
// Shared constants and FSM state type for the sequential single-precision multiplier.
package float_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam logic [EXP_W-1:0] BIAS = 8'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Biased exponent of the product before normalisation; wraps modulo 256.
    function automatic logic [EXP_W-1:0] exp_sum(input logic [EXP_W-1:0] ea,
                                                 input logic [EXP_W-1:0] eb);
        exp_sum = ea + eb - BIAS;
    endfunction

endpackage

// File: rtl/mant_mul_iter.sv
// Iterative 24x24 mantissa multiplier: retires BITS_PER_CYCLE multiplier bits per
// cycle (LSB first); done is a one-cycle pulse registered after the last iteration.
module mant_mul_iter
    import float_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    output logic              done,
    output logic [PROD_W-1:0] prod
);

    localparam int ITERS = MANT_W / BITS_PER_CYCLE;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    logic [PROD_W-1:0] a_q;
    logic [MANT_W-1:0] b_q;
    logic [PROD_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [PROD_W-1:0] pp_s;

    // Partial product of the pre-shifted multiplicand and the current multiplier chunk.
    always_comb begin
        pp_s = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_q[j]) begin
                pp_s = pp_s + (a_q << j);
            end else begin
                pp_s = pp_s;
            end
        end
    end

    // Operand load on start, then shift-and-add until the counter reaches the last chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            a_q    <= {{MANT_W{1'b0}}, a};
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            acc_q  <= acc_q + pp_s;
            a_q    <= a_q << BITS_PER_CYCLE;
            b_q    <= b_q >> BITS_PER_CYCLE;
            cnt_q  <= cnt_q + 5'd1;
            busy_q <= (cnt_q != LAST_CNT);
            done_q <= (cnt_q == LAST_CNT);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/float_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier (truncating, no special-value
// handling beyond zero exponent) built around an iterative mantissa datapath.
module float_mul_seq
    import float_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] vres
);

    state_t            state_q, state_d;
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic              zero_q;
    logic [31:0]       vres_q, vres_d;
    logic              start_s;
    logic              mul_done_s;
    logic [PROD_W-1:0] prod_s;

    mant_mul_iter #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mant (
        .clk  (clk),
        .rst  (rst),
        .start(start_s),
        .a    ({1'b1, v1[FRAC_W-1:0]}),
        .b    ({1'b1, v2[FRAC_W-1:0]}),
        .done (mul_done_s),
        .prod (prod_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, accept strobe and result packing.
    always_comb begin
        state_d = state_q;
        start_s = 1'b0;
        vres_d  = vres_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    start_s = 1'b1;
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_d = NORM;
                end else begin
                    state_d = MUL;
                end
            end
            NORM: begin
                // A zero exponent field forces signed zero; otherwise normalise by p[47].
                if (zero_q) begin
                    vres_d = {sign_q, 31'd0};
                end else if (prod_s[PROD_W-1]) begin
                    vres_d = {sign_q, exp_q + 8'd1, prod_s[46:24]};
                end else begin
                    vres_d = {sign_q, exp_q, prod_s[45:23]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sign, exponent and zero flag captured at accept; result held until the next NORM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            vres_q <= 32'h0000_0000;
        end else begin
            if (start_s) begin
                sign_q <= v1[31] ^ v2[31];
                exp_q  <= exp_sum(v1[30:23], v2[30:23]);
                zero_q <= (v1[30:23] == 8'h00) || (v2[30:23] == 8'h00);
            end else begin
                sign_q <= sign_q;
                exp_q  <= exp_q;
                zero_q <= zero_q;
            end
            vres_q <= vres_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign vres      = vres_q;

endmodule

// File: tb/tb_float_mul_seq.sv
// Scoreboard bench for float_mul_seq: directed vectors with hand-computed products,
// checked for value and latency on each out_valid rise, plus handshake and reset cases.
module tb_float_mul_seq;

    typedef struct {
        logic [31:0] v;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv1 = 1'b0, iv8 = 1'b0;
    logic        ir1, ir8;
    logic [31:0] a1 = 32'h0, b1 = 32'h0, a8 = 32'h0, b8 = 32'h0;
    logic        ov1, ov8;
    logic        or1 = 1'b1, or8 = 1'b1;
    logic [31:0] r1, r8;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q1[$];
    exp_t q8[$];
    logic pv1 = 1'b0, pv8 = 1'b0;

    float_mul_seq #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .v1(a1), .v2(b1),
        .out_valid(ov1), .out_ready(or1), .vres(r1)
    );

    float_mul_seq #(.BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .v1(a8), .v2(b8),
        .out_valid(ov8), .out_ready(or8), .vres(r8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor for the BITS_PER_CYCLE=1 instance.
    always @(negedge clk) begin
        if (ov1 && !pv1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("d1_vres", r1, e.v);
                chk("d1_latency_cycle", 32'(cyc), 32'(e.due));
            end
        end
        pv1 <= ov1;
    end

    // Monitor for the BITS_PER_CYCLE=8 instance.
    always @(negedge clk) begin
        if (ov8 && !pv8) begin
            if (q8.size() == 0) begin
                chk("d8_unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("d8_vres", r8, e.v);
                chk("d8_latency_cycle", 32'(cyc), 32'(e.due));
            end
        end
        pv8 <= ov8;
    end

    task automatic send(input bit sel, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int lat, input bit track);
        int   n;
        exp_t it;
        n = 0;
        @(negedge clk);
        while (!(sel ? ir8 : ir1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready_timeout", 32'(n >= 100), 32'd0);
        if (sel) begin iv8 = 1'b1; a8 = x; b8 = y; end
        else     begin iv1 = 1'b1; a1 = x; b1 = y; end
        @(posedge clk);
        #1;
        it.v   = e;
        it.due = cyc + lat;
        if (track) begin
            if (sel) q8.push_back(it);
            else     q1.push_back(it);
        end
        iv1 = 1'b0;
        iv8 = 1'b0;
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while (((sel ? q8.size() : q1.size()) != 0 || !(sel ? ir8 : ir1)) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 80), 32'd0);
    endtask

    initial begin
        int n;
        int rises;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(ir1), 32'd1);
        chk("reset_out_valid", 32'(ov1), 32'd0);
        chk("reset_vres", r1, 32'h0000_0000);
        chk("reset_vres_d8", r8, 32'h0000_0000);
        rst = 1'b0;

        // Directed products: normal, normalise-up, signs, zeros, exponent wrap, full mantissa.
        send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 26, 1'b1); drain(1'b0);
        send(1'b0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 26, 1'b1); drain(1'b0);
        send(1'b0, 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 26, 1'b1); drain(1'b0);
        send(1'b0, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 26, 1'b1); drain(1'b0);
        send(1'b0, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 26, 1'b1); drain(1'b0);
        send(1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000, 26, 1'b1); drain(1'b0);
        send(1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 26, 1'b1); drain(1'b0);

        // Back-pressure in DONE: result and state held, operands ignored.
        or1 = 1'b0;
        send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 26, 1'b1);
        n = 0;
        while (!ov1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("hold_wait_timeout", 32'(n >= 60), 32'd0);
        for (int k = 0; k < 5; k++) begin
            iv1 = 1'b1; a1 = 32'h3F80_0000; b1 = 32'h3F80_0000;
            @(negedge clk);
            chk("hold_vres", r1, 32'h40C0_0000);
            chk("hold_in_ready", 32'(ir1), 32'd0);
            chk("hold_out_valid", 32'(ov1), 32'd1);
        end
        or1 = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(ir1), 32'd1);
        chk("release_out_valid", 32'(ov1), 32'd0);
        chk("release_vres_kept", r1, 32'h40C0_0000);
        iv1 = 1'b0;
        @(negedge clk);
        chk("release_no_accept", 32'(ir1), 32'd1);

        // Reset ten cycles into an operation: no result for it.
        send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 26, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(ir1), 32'd1);
        chk("abort_out_valid", 32'(ov1), 32'd0);
        chk("abort_vres", r1, 32'h0000_0000);
        rises = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ov1) rises++;
        end
        chk("abort_no_out_valid", 32'(rises), 32'd0);

        // Eight bits per cycle: same products, five-cycle latency.
        send(1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5, 1'b1); drain(1'b1);
        send(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5, 1'b1); drain(1'b1);
        send(1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 5, 1'b1); drain(1'b1);

        chk("d1_queue_empty", 32'(q1.size()), 32'd0);
        chk("d8_queue_empty", 32'(q8.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_mul_seq.md
FLOAT_MUL_SEQ -- requirements
Module: float_mul_seq

Interface
REQ-001 SHALL provide parameter BITS_PER_CYCLE, default 1, multiplier bits retired per iteration; legal values 1, 2, 4, 8.
REQ-002 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide in_valid  input  1  operand pair v1/v2 present.
REQ-005 SHALL provide in_ready  output  1  block can accept operands.
REQ-006 SHALL provide v1  input  32  multiplicand, IEEE-754 single layout {sign, exp[7:0], frac[22:0]}.
REQ-007 SHALL provide v2  input  32  multiplier, same layout.
REQ-008 SHALL provide out_valid  output  1  vres holds a finished product.
REQ-009 SHALL provide out_ready  input  1  consumer takes vres.
REQ-010 SHALL provide vres  output  32  product, same layout.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, NORM, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready SHALL register sign v1[31]^v2[31], exponent sum v1[30:23]+v2[30:23]-8'h7F (8-bit modulo), mantissas {1,frac}, clear 48-bit product and iteration counter, go to MUL.
REQ-013 MUL: each cycle SHALL add (mantissa A x next BITS_PER_CYCLE bits of mantissa B, LSB first) into the 48-bit accumulator; after 24/BITS_PER_CYCLE cycles go to NORM.
REQ-014 NORM: if p[47]=1 SHALL form vres={sign, exp+1, p[46:24]}; else vres={sign, exp, p[45:23]}; go to DONE.
REQ-015 Fraction SHALL be truncated (no rounding); exponent overflow/underflow SHALL wrap modulo 256 without flagging.
REQ-016 If either operand exponent field is 8'h00, result SHALL be {sign, 31'b0} (signed zero); MUL iterations still run, latency unchanged.
REQ-017 DONE: out_valid=1, vres stable; on out_ready SHALL return to IDLE next cycle.
REQ-018 in_ready SHALL be 1 only in IDLE; no operand accepted in DONE even if out_ready is high the same cycle.
REQ-019 Latency from accept edge to out_valid high SHALL be 24/BITS_PER_CYCLE + 2 cycles (26 at default).
REQ-020 out_valid held with out_ready low SHALL keep vres and state unchanged indefinitely.
REQ-021 vres SHALL keep its last value after out_valid falls, until the next NORM.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, out_valid=0, in_ready=1 next cycle, vres=32'h0, counter and accumulator cleared.
REQ-023 rst mid-MUL/NORM/DONE SHALL abandon the operation; no out_valid pulse for it.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-025 Shared package float_pkg SHALL hold EXP_W=8, FRAC_W=23, BIAS=8'h7F, and the FSM state typedef.
REQ-026 Iterative mantissa datapath (accumulator, shift, counter) SHALL be sub-module mant_mul_iter with start/done; FSM, exponent and packing stay in float_mul_seq.

Verification
REQ-027 v1=0x40000000, v2=0x40400000 -> vres=0x40C00000, out_valid exactly 26 cycles after accept.
REQ-028 v1=0x3FC00000, v2=0x3FC00000 -> vres=0x40100000 (p[47]=1 normalize path).
REQ-029 v1=0xC0000000, v2=0x3F000000 -> 0xBF800000; v1=0x80000000, v2=0x3F800000 -> 0x80000000.
REQ-030 out_ready held low 5 cycles in DONE -> vres stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-031 rst asserted 10 cycles after accept -> out_valid never rises for that operation, in_ready=1 the cycle after reset.
REQ-032 Repeat REQ-027 with BITS_PER_CYCLE=8 -> same vres, latency 5 cycles.
